uart_tx_arbiter: RTL and testbench

//  Shares one UART transmitter byte interface among NUM_REQ requesters (e.g. 7-seg echo,

---
 rtl/uart_tx_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter byte interface among NUM_REQ byte producers with
// round-robin arbitration. A one-deep output register holds the byte presented
// to the UART TX, so a new byte can be loaded in the same cycle the UART takes
// the previous one (no bubble while a grant is held).
//
// Build option:
//   UART_ARB_LOCK_EN  defined   -> packet lock: a grant is held until the byte
//                                  carrying req_last is accepted, or until
//                                  MAX_PKT_LEN bytes have been accepted.
//                     undefined -> grant released after every accepted byte
//                                  (byte-level round-robin); req_last and
//                                  MAX_PKT_LEN are ignored.
//
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous reset, active-low
//   req_valid  in   [NUM_REQ]         per-requester byte valid
//   req_data   in   [NUM_REQ*DATA_W]  requester i byte on [i*DATA_W +: DATA_W]
//   req_last   in   [NUM_REQ]         byte is last of packet (lock mode only)
//   req_ready  out  [NUM_REQ]         per-requester byte accept (one-hot or 0)
//   tx_valid   out  byte available to UART TX
//   tx_data    out  [DATA_W]          byte to UART TX
//   tx_ready   in   UART TX takes tx_data when tx_valid & tx_ready
//   grant_id   out  [$clog2(NUM_REQ)] current / last granted requester
//   busy       out  arbiter holds a grant or a pending byte
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int MAX_PKT_LEN = 64
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx_valid,
    output logic [DATA_W-1:0]             tx_data,
    input  logic                          tx_ready,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int         ID_W    = $clog2(NUM_REQ);
    localparam logic [6:0] MAX_CNT = 7'(MAX_PKT_LEN);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [ID_W-1:0]    grant_id_r;
    logic [ID_W-1:0]    grant_nxt_s;
    logic [ID_W-1:0]    rr_ptr_r;
    logic [ID_W-1:0]    rr_nxt_s;
    logic [6:0]         byte_cnt_r;
    logic               cnt_clr_s;
    logic               tx_valid_r;
    logic [DATA_W-1:0]  tx_data_r;

    logic [ID_W-1:0]    pick_s;
    logic [ID_W-1:0]    pick_hi_s;
    logic [ID_W-1:0]    pick_lo_s;
    logic               found_hi_s;
    logic               any_valid_s;
    logic [NUM_REQ-1:0] grant_oh_s;
    logic [DATA_W-1:0]  sel_data_s;
    logic               sel_valid_s;
    logic               sel_last_s;
    logic               ready_s;
    logic               req_hs_s;
    logic               tx_hs_s;
    logic               release_s;

    // Round-robin pick: lowest valid index above rr_ptr, else lowest valid index (wrap).
    always_comb begin
        pick_hi_s   = '0;
        pick_lo_s   = '0;
        found_hi_s  = 1'b0;
        any_valid_s = |req_valid;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (ID_W'(i) > rr_ptr_r)) begin
                pick_hi_s  = ID_W'(i);
                found_hi_s = 1'b1;
            end else begin
                pick_hi_s  = pick_hi_s;
            end
            if (req_valid[i]) begin
                pick_lo_s = ID_W'(i);
            end else begin
                pick_lo_s = pick_lo_s;
            end
        end
        if (found_hi_s) begin
            pick_s = pick_hi_s;
        end else begin
            pick_s = pick_lo_s;
        end
    end

    // Select the granted requester's valid, byte and last flag, and its one-hot mask.
    always_comb begin
        grant_oh_s  = '0;
        sel_data_s  = '0;
        sel_valid_s = 1'b0;
        sel_last_s  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_r == ID_W'(i)) begin
                grant_oh_s[i] = 1'b1;
                sel_data_s    = req_data[i*DATA_W +: DATA_W];
                sel_valid_s   = req_valid[i];
                sel_last_s    = req_last[i];
            end else begin
                grant_oh_s[i] = 1'b0;
            end
        end
    end

    // Handshakes: the granted requester may load whenever the output register is free or draining.
    always_comb begin
        ready_s  = (state_r == ST_GRANT) && (!tx_valid_r || tx_ready);
        req_hs_s = ready_s && sel_valid_s;
        tx_hs_s  = tx_valid_r && tx_ready;
        if (ready_s) begin
            req_ready = grant_oh_s;
        end else begin
            req_ready = '0;
        end
    end

`ifdef UART_ARB_LOCK_EN
    // Packet lock: release on the last byte or on the byte that brings the count to MAX_PKT_LEN.
    always_comb begin
        release_s = req_hs_s && (sel_last_s || (byte_cnt_r >= (MAX_CNT - 7'd1)));
    end
`else
    logic unused_lock_s;
    // Byte-level round-robin: every accepted byte ends the grant.
    always_comb begin
        release_s     = req_hs_s;
        unused_lock_s = ^{sel_last_s, byte_cnt_r};
    end
`endif

    // FSM next state, next grant and round-robin pointer update.
    always_comb begin
        state_nxt_s = state_r;
        grant_nxt_s = grant_id_r;
        rr_nxt_s    = rr_ptr_r;
        cnt_clr_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (any_valid_s) begin
                    state_nxt_s = ST_GRANT;
                    grant_nxt_s = pick_s;
                    cnt_clr_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (release_s) begin
                    state_nxt_s = ST_IDLE;
                    rr_nxt_s    = grant_id_r;
                end else begin
                    state_nxt_s = ST_GRANT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, grant and round-robin pointer registers; pointer resets so requester 0 wins first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            grant_id_r <= '0;
            rr_ptr_r   <= ID_W'(NUM_REQ - 1);
        end else begin
            state_r    <= state_nxt_s;
            grant_id_r <= grant_nxt_s;
            rr_ptr_r   <= rr_nxt_s;
        end
    end

    // Output byte register: a load wins over a drain, so back-to-back bytes leave no bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_valid_r <= 1'b0;
            tx_data_r  <= '0;
        end else if (req_hs_s) begin
            tx_valid_r <= 1'b1;
            tx_data_r  <= sel_data_s;
        end else if (tx_hs_s) begin
            tx_valid_r <= 1'b0;
        end
    end

    // Per-grant byte counter, saturating at MAX_PKT_LEN.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt_r <= 7'd0;
        end else if (cnt_clr_s) begin
            byte_cnt_r <= 7'd0;
        end else if (req_hs_s && (byte_cnt_r < MAX_CNT)) begin
            byte_cnt_r <= byte_cnt_r + 7'd1;
        end
    end

    assign tx_valid = tx_valid_r;
    assign tx_data  = tx_data_r;
    assign grant_id = grant_id_r;
    assign busy     = (state_r != ST_IDLE) || tx_valid_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter (NUM_REQ=4, DATA_W=8, MAX_PKT_LEN=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// The packet-lock scenarios run only when UART_ARB_LOCK_EN is defined.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    logic        clk;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [1:0]  grant_id;
    logic        busy;

    int chk_cnt;
    int pass_cnt;
    int fail_cnt;

    uart_tx_arbiter #(
        .NUM_REQ     (4),
        .DATA_W      (8),
        .MAX_PKT_LEN (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = 4'b0000;
        req_last  = 4'b0000;
        tx_ready  = 1'b1;
        reset_n   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n   = 1'b1;
    endtask

    initial begin
        chk_cnt   = 0;
        pass_cnt  = 0;
        fail_cnt  = 0;
        req_data  = 32'h0;
        req_valid = 4'b0000;
        req_last  = 4'b0000;
        tx_ready  = 1'b1;
        reset_n   = 1'b0;
        #1;
        do_reset();

        // Reset state
        check("rst_tx_valid",  32'(tx_valid),  32'd0);
        check("rst_tx_data",   32'(tx_data),   32'h0);
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_grant_id",  32'(grant_id),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);

        // Single requester: grant after 1 edge, byte on tx after 2 edges
        req_data  = 32'h0000_0041;
        req_last  = 4'b1111;
        req_valid = 4'b0001;
        tick();
        check("t1_grant",     32'(grant_id),  32'd0);
        check("t1_ready",     32'(req_ready), 32'h1);
        check("t1_nobyte",    32'(tx_valid),  32'd0);
        tick();
        check("t1_tx_valid",  32'(tx_valid),  32'd1);
        check("t1_tx_data",   32'(tx_data),   32'h41);
        check("t1_busy",      32'(busy),      32'd1);
        req_valid = 4'b0000;
        tick();
        check("t1_drain",     32'(tx_valid),  32'd0);
        check("t1_idle_busy", 32'(busy),      32'd0);
        check("t1_grant_hold", 32'(grant_id), 32'd0);

        // All requesting: rotation 0,1,2,3,0 with one byte each
        do_reset();
        req_data  = 32'h1312_1110;
        req_last  = 4'b1111;
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t2_grant", 32'(grant_id),  32'(k % 4));
            check("t2_ready", 32'(req_ready), 32'(1 << (k % 4)));
            tick();
            check("t2_tx_valid", 32'(tx_valid), 32'd1);
            check("t2_tx_data",  32'(tx_data),  32'h10 + 32'(k % 4));
        end
        req_valid = 4'b0000;
        tick();
        check("t2_idle_busy", 32'(busy), 32'd0);

        // Back-pressure: held byte stable, reload in the same cycle the UART takes it
        req_data  = 32'h0000_00A5;
        req_valid = 4'b0001;
        tx_ready  = 1'b0;
        tick();
        check("t5_grant",     32'(grant_id),  32'd0);
        check("t5_ready0",    32'(req_ready), 32'h1);
        tick();
        check("t5_load_v",    32'(tx_valid),  32'd1);
        check("t5_load_d",    32'(tx_data),   32'hA5);
        tick();
        check("t5_blocked",   32'(req_ready), 32'h0);
        check("t5_held_v",    32'(tx_valid),  32'd1);
        req_data = 32'h0000_005A;
        tick();
        check("t5_stable",    32'(tx_data),   32'hA5);
        tx_ready = 1'b1;
        #1;
        check("t5_ready1",    32'(req_ready), 32'h1);
        tick();
        check("t5_nobubble",  32'(tx_valid),  32'd1);
        check("t5_replaced",  32'(tx_data),   32'h5A);
        req_valid = 4'b0000;
        tick();
        check("t5_drain",     32'(tx_valid),  32'd0);

        // Async reset in GRANT with a pending byte
        req_data  = 32'h0077_0000;
        req_valid = 4'b0100;
        tx_ready  = 1'b0;
        tick();
        check("t6_grant2",    32'(grant_id),  32'd2);
        tick();
        check("t6_byte",      32'(tx_data),   32'h77);
        req_data  = 32'h1312_1110;
        req_valid = 4'b1111;
        tick();
        check("t6_grant3",    32'(grant_id),  32'd3);
        check("t6_busy",      32'(busy),      32'd1);
        check("t6_pending",   32'(tx_valid),  32'd1);
        reset_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(tx_valid),  32'd0);
        check("t6_rst_ready", 32'(req_ready), 32'h0);
        check("t6_rst_busy",  32'(busy),      32'd0);
        check("t6_rst_data",  32'(tx_data),   32'h0);
        check("t6_rst_grant", 32'(grant_id),  32'd0);
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        tx_ready = 1'b1;
        tick();
        check("t6_first0",    32'(grant_id),  32'd0);
        tick();
        check("t6_first_d",   32'(tx_data),   32'h10);

`ifdef UART_ARB_LOCK_EN
        // Packet lock: "abc" from requester 1 contiguous while requester 2 waits
        do_reset();
        req_data  = 32'h0032_6100;
        req_last  = 4'b0000;
        req_valid = 4'b0110;
        tick();
        check("t3_grant1",    32'(grant_id),  32'd1);
        tick();
        check("t3_a",         32'(tx_data),   32'h61);
        req_data = 32'h0032_6200;
        tick();
        check("t3_b",         32'(tx_data),   32'h62);
        check("t3_hold1",     32'(grant_id),  32'd1);
        req_data = 32'h0032_6300;
        req_last = 4'b0010;
        tick();
        check("t3_c",         32'(tx_data),   32'h63);
        req_valid = 4'b0100;
        req_last  = 4'b0000;
        tick();
        check("t3_grant2",    32'(grant_id),  32'd2);

        // Packet lock: forced release after MAX_PKT_LEN bytes
        do_reset();
        req_last  = 4'b0000;
        req_valid = 4'b1001;
        req_data  = 32'h0000_00B0;
        tick();
        check("t4_grant0",    32'(grant_id),  32'd0);
        for (int b = 0; b < 4; b++) begin
            req_data = 32'hB0 + 32'(b);
            tick();
            check("t4_byte",  32'(tx_data),   32'hB0 + 32'(b));
            check("t4_hold0", 32'(grant_id),  32'd0);
        end
        req_data = 32'h0000_00B4;
        tick();
        check("t4_grant3",    32'(grant_id),  32'd3);
        check("t4_drain",     32'(tx_valid),  32'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
